cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Moore control FSM that sequences the 16-bit simple-RISC datapath: register file, A/B/C registers, shifter/ALU, status flags, PC, data-address register and shared synchronous RAM.
- Sits beside the datapath inside the CPU top.
- Fetches each instruction over the single RAM port, decodes opcode/op, and drives every load-enable and mux select cycle by cycle until HALT.
- Owns all RAM write timing and arbitrates the RAM address mux between instruction fetch and LDR/STR data access.

Parameters:
- STATE_W, 4, width of state register and state_dbg output
- RAM_RD_LAT, 1, cycles between RAM address valid and RAM read data valid; legal values 1..2; each FETCH_WAIT/MEM_WAIT state repeats this many cycles

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- opcode  in  3  IR[15:13]
- op  in  2  IR[12:11]
- reg_sel  out  2  register-file index mux: 00=Rn, 01=Rd, 10=Rm
- wb_sel  out  2  writeback mux: 00=C, 01=RAM rdata, 10=sext(imm8), 11=PC
- w_en  out  1  register-file write enable
- en_A, en_B, en_C  out  1 each  A/B/C register load enables
- en_status  out  1  status-flag load enable
- sel_A  out  1  1=ALU A input forced to 0
- sel_B  out  1  1=ALU B input is sext(imm5)
- load_pc  out  1  PC load enable
- pc_sel  out  1  0=start_pc, 1=PC+1
- load_ir  out  1  IR load enable
- load_addr  out  1  data-address register load (from C[7:0])
- sel_addr  out  1  RAM address mux: 0=PC, 1=data-address register
- ram_w_en  out  1  RAM write enable
- halted  out  1  high in HALT state
- state_dbg  out  STATE_W  current state encoding

Behaviour:
- Moore: all outputs decode from the state register only. Any output not listed for a state is 0.
- rst asserted: state=RST immediately (async). All outputs are 0 while rst is high, so w_en and ram_w_en drop mid-operation with no partial write on the next edge.
- RST: load_pc=1, pc_sel=0 -> FETCH.
- FETCH: sel_addr=0 -> FETCH_WAIT.
- FETCH_WAIT: sel_addr=0; held RAM_RD_LAT cycles -> LOAD_IR.
- LOAD_IR: load_ir=1, load_pc=1, pc_sel=1 -> DECODE.
- DECODE: no enables. Branches on {opcode,op}:
  - 110_10 MOV imm -> WB_IMM
  - 110_00 MOV reg -> GET_B
  - 101_11 MVN -> GET_B
  - 101_xx ADD/CMP/AND -> GET_A
  - 011_00 LDR -> GET_A
  - 100_00 STR -> GET_A
  - 111_xx -> HALT
  - any other encoding: see optional feature.
- WB_IMM: reg_sel=00, wb_sel=10, w_en=1 -> FETCH.
- GET_A: reg_sel=00, en_A=1 -> GET_B for ALU ops; -> ADDR_CALC for LDR/STR.
- GET_B: reg_sel=10, en_B=1 -> EXEC.
- EXEC: en_C=1; sel_A=1 for MOV reg and MVN; en_status=1 for CMP only (en_C still 1). CMP -> FETCH; others -> WB.
- WB: reg_sel=01, wb_sel=00, w_en=1 -> FETCH.
- ADDR_CALC: sel_B=1, en_C=1 -> LOAD_ADDR.
- LOAD_ADDR: load_addr=1 -> MEM_WAIT for LDR; -> GET_D for STR.
- MEM_WAIT: sel_addr=1; held RAM_RD_LAT cycles -> WB_MEM.
- WB_MEM: sel_addr=1, reg_sel=01, wb_sel=01, w_en=1 -> FETCH.
- GET_D: reg_sel=01, en_B=1 -> PASS_D.
- PASS_D: sel_A=1, en_C=1 -> STR_WR.
- STR_WR: sel_addr=1, ram_w_en=1 (exactly one cycle) -> FETCH.
- HALT: halted=1, no enables; stays in HALT until rst.
- Cycle counts from FETCH entry back to FETCH (RAM_RD_LAT=1): MOV imm 4, MOV reg/MVN/CMP 6, ADD/AND 7, LDR 8, STR 9.
- Each RAM_RD_LAT above 1 adds one cycle per wait state used.
- Wait-state repeat counter is cleared on every wait-state entry and on rst.
- ram_w_en and w_en are never high in the same cycle.

Optional Feature:
- Macro: CPU_SEQ_ILLEGAL_TRAP_EN.
- Defined: an unlisted encoding in DECODE -> HALT, and a sticky output illegal (1 bit, reset 0) sets and holds until rst.
- Undefined: an unlisted encoding is a NOP; DECODE -> FETCH with no enables. The illegal port does not exist.

Test Plan:
- Pulse rst high for 2 cycles mid-EXEC of ADD -> state_dbg=RST and w_en=0 during rst; after release, load_pc=1 with pc_sel=0 for exactly one cycle.
- MOV R0,#2 then HALT -> w_en high exactly once, 4 cycles after FETCH entry, with wb_sel=10; halted=1 is held for 20+ cycles.
- ADD after two MOV imm instructions -> en_A, then en_B, then en_C on consecutive cycles; WB has w_en=1, reg_sel=01; 7 cycles FETCH-to-FETCH.
- CMP -> en_status=1 in exactly one cycle, w_en never asserted; returns to FETCH after 6 cycles.
- LDR then STR -> LDR: sel_addr=1 in MEM_WAIT and WB_MEM, wb_sel=01. STR: ram_w_en=1 for exactly one cycle with sel_addr=1, 9 cycles total. ram_w_en and w_en never high together.
- Opcode 001 with macro defined -> HALT and illegal=1. Without macro -> back to FETCH 3 cycles after FETCH entry, no enables asserted.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Moore sequencer for the 16-bit simple-RISC datapath: fetch, decode, execute.
// Define CPU_SEQ_ILLEGAL_TRAP_EN to halt on unlisted opcodes and raise `illegal`.
module cpu_seq_ctrl #(
  parameter int STATE_W    = 4,
  parameter int RAM_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic [1:0]         op,
  output logic [1:0]         reg_sel,
  output logic [1:0]         wb_sel,
  output logic               w_en,
  output logic               en_A,
  output logic               en_B,
  output logic               en_C,
  output logic               en_status,
  output logic               sel_A,
  output logic               sel_B,
  output logic               load_pc,
  output logic               pc_sel,
  output logic               load_ir,
  output logic               load_addr,
  output logic               sel_addr,
  output logic               ram_w_en,
  output logic               halted,
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  output logic               illegal,
`endif
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RST        = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_LOAD_IR    = 4'd3,
    S_DECODE     = 4'd4,
    S_GET_A      = 4'd5,
    S_GET_B      = 4'd6,
    S_EXEC       = 4'd7,
    S_WB         = 4'd8,
    S_ADDR_CALC  = 4'd9,
    S_LOAD_ADDR  = 4'd10,
    S_MEM_WAIT   = 4'd11,
    S_GET_D      = 4'd12,
    S_PASS_D     = 4'd13,
    S_STR_WR     = 4'd14,
    S_HALT       = 4'd15
  } state_t;

  // Instruction class latched in DECODE; WB doubles as WB_IMM and WB_MEM.
  typedef enum logic [2:0] {
    K_MOVI, K_MOVR, K_MVN, K_ADD,
    K_CMP,  K_AND,  K_LDR, K_STR
  } kind_t;

  state_t     state;
  kind_t      kind;
  kind_t      alu_kind;
  logic [1:0] wcnt;
  logic       last_wait;
  logic       mem_op;
  logic       is_movi;
  logic       is_movr;
  logic       is_mvn;
  logic       is_alu;
  logic       is_ldr;
  logic       is_str;
  logic       is_hlt;

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu  = (opcode == 3'b101) && (op != 2'b11);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);
  assign is_hlt  = (opcode == 3'b111);

  assign last_wait = (wcnt == 2'(RAM_RD_LAT - 1));
  assign mem_op    = (kind == K_LDR) || (kind == K_STR);
  assign state_dbg = STATE_W'(state);

  always_comb begin
    alu_kind = K_AND;
    if (op == 2'b00)
      alu_kind = K_ADD;
    else if (op == 2'b01)
      alu_kind = K_CMP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RST;
      kind    <= K_MOVI;
      wcnt    <= 2'd0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      case (state)
        S_RST:   state <= S_FETCH;
        S_FETCH: begin
          state <= S_FETCH_WAIT;
          wcnt  <= 2'd0;
        end
        S_FETCH_WAIT: begin
          if (last_wait)
            state <= S_LOAD_IR;
          else
            wcnt <= wcnt + 2'd1;
        end
        S_LOAD_IR: state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            is_movi: begin
              state <= S_WB;
              kind  <= K_MOVI;
            end
            is_movr: begin
              state <= S_GET_B;
              kind  <= K_MOVR;
            end
            is_mvn: begin
              state <= S_GET_B;
              kind  <= K_MVN;
            end
            is_alu: begin
              state <= S_GET_A;
              kind  <= alu_kind;
            end
            is_ldr: begin
              state <= S_GET_A;
              kind  <= K_LDR;
            end
            is_str: begin
              state <= S_GET_A;
              kind  <= K_STR;
            end
            is_hlt: state <= S_HALT;
            default: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
              state   <= S_HALT;
              illegal <= 1'b1;
`else
              state <= S_FETCH;
`endif
            end
          endcase
        end
        S_GET_A: state <= mem_op ? S_ADDR_CALC : S_GET_B;
        S_GET_B: state <= S_EXEC;
        S_EXEC:  state <= (kind == K_CMP) ? S_FETCH : S_WB;
        S_WB:    state <= S_FETCH;
        S_ADDR_CALC: state <= S_LOAD_ADDR;
        S_LOAD_ADDR: begin
          if (kind == K_LDR) begin
            state <= S_MEM_WAIT;
            wcnt  <= 2'd0;
          end else begin
            state <= S_GET_D;
          end
        end
        S_MEM_WAIT: begin
          if (last_wait)
            state <= S_WB;
          else
            wcnt <= wcnt + 2'd1;
        end
        S_GET_D:  state <= S_PASS_D;
        S_PASS_D: state <= S_STR_WR;
        S_STR_WR: state <= S_FETCH;
        S_HALT:   state <= S_HALT;
      endcase
    end
  end

  // Outputs are forced low during rst so no write lands on the next edge.
  always_comb begin
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_pc   = 1'b0;
    pc_sel    = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    sel_addr  = 1'b0;
    ram_w_en  = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (state)
        S_RST: load_pc = 1'b1;
        S_LOAD_IR: begin
          load_ir = 1'b1;
          load_pc = 1'b1;
          pc_sel  = 1'b1;
        end
        S_GET_A: en_A = 1'b1;
        S_GET_B: begin
          reg_sel = 2'b10;
          en_B    = 1'b1;
        end
        S_EXEC: begin
          en_C      = 1'b1;
          sel_A     = (kind == K_MOVR) || (kind == K_MVN);
          en_status = (kind == K_CMP);
        end
        S_WB: begin
          w_en = 1'b1;
          if (kind == K_MOVI) begin
            wb_sel = 2'b10;
          end else if (kind == K_LDR) begin
            sel_addr = 1'b1;
            reg_sel  = 2'b01;
            wb_sel   = 2'b01;
          end else begin
            reg_sel = 2'b01;
          end
        end
        S_ADDR_CALC: begin
          sel_B = 1'b1;
          en_C  = 1'b1;
        end
        S_LOAD_ADDR: load_addr = 1'b1;
        S_MEM_WAIT:  sel_addr = 1'b1;
        S_GET_D: begin
          reg_sel = 2'b01;
          en_B    = 1'b1;
        end
        S_PASS_D: begin
          sel_A = 1'b1;
          en_C  = 1'b1;
        end
        S_STR_WR: begin
          sel_addr = 1'b1;
          ram_w_en = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: driver feeds IR opcodes, monitor checks.
module tb_cpu_seq_ctrl;

  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_EXEC  = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd15;

  localparam logic [4:0] MOVI = 5'b110_10;
  localparam logic [4:0] MOVR = 5'b110_00;
  localparam logic [4:0] MVN  = 5'b101_11;
  localparam logic [4:0] ADD  = 5'b101_00;
  localparam logic [4:0] CMP  = 5'b101_01;
  localparam logic [4:0] AND_ = 5'b101_10;
  localparam logic [4:0] LDR  = 5'b011_00;
  localparam logic [4:0] STR  = 5'b100_00;
  localparam logic [4:0] HLT  = 5'b111_00;
  localparam logic [4:0] ILL  = 5'b001_00;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [1:0] reg_sel, wb_sel;
  logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
  logic       load_pc, pc_sel, load_ir, load_addr, sel_addr;
  logic       ram_w_en, halted;
  logic [3:0] state_dbg;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .op(op),
    .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en),
    .en_A(en_A), .en_B(en_B), .en_C(en_C),
    .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B),
    .load_pc(load_pc), .pc_sel(pc_sel), .load_ir(load_ir),
    .load_addr(load_addr), .sel_addr(sel_addr),
    .ram_w_en(ram_w_en), .halted(halted),
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cyc; int wen; int stat; int ramw;
    int a_off; int b_off; int c_off; int ens;
    int sa_cnt; int wsel; int rsel; int sa; int halt;
  } rec_t;

  rec_t       sb[$];
  logic [4:0] prog[$];
  int         pi = 0;
  int         checks = 0;
  int         passes = 0;
  int         overlap = 0;
  int         idx = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Hand-computed per-instruction response (RAM_RD_LAT = 1).
  function automatic rec_t expect_of(logic [4:0] ins);
    rec_t r;
    r = '0;
    r.a_off = -1; r.b_off = -1; r.c_off = -1;
    case (ins)
      MOVI: begin
        r.cyc = 4; r.wen = 1; r.ens = 1; r.wsel = 2; r.rsel = 0;
      end
      MOVR, MVN: begin
        r.cyc = 6; r.wen = 1; r.b_off = 4; r.c_off = 5;
        r.ens = 3; r.wsel = 0; r.rsel = 1;
      end
      ADD, AND_: begin
        r.cyc = 7; r.wen = 1; r.a_off = 4; r.b_off = 5; r.c_off = 6;
        r.ens = 4; r.wsel = 0; r.rsel = 1;
      end
      CMP: begin
        r.cyc = 6; r.stat = 1; r.a_off = 4; r.b_off = 5; r.c_off = 6;
        r.ens = 3;
      end
      LDR: begin
        r.cyc = 8; r.wen = 1; r.a_off = 4; r.c_off = 5; r.ens = 4;
        r.sa_cnt = 2; r.wsel = 1; r.rsel = 1; r.sa = 1;
      end
      STR: begin
        r.cyc = 9; r.ramw = 1; r.a_off = 4; r.b_off = 7; r.c_off = 5;
        r.ens = 6; r.sa_cnt = 1; r.sa = 1;
      end
      HLT: begin
        r.cyc = 3; r.halt = 1;
      end
      default: begin
        r.cyc = 3;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        r.halt = 1;
`endif
      end
    endcase
    return r;
  endfunction

  // Driver: IR loads the next program word whenever load_ir is seen.
  initial begin
    logic [4:0] ins;
    opcode = 3'b000;
    op     = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst && load_ir) begin
        ins = (pi < prog.size()) ? prog[pi] : HLT;
        pi++;
        {opcode, op} = ins;
        sb.push_back(expect_of(ins));
      end
    end
  end

  // Monitor: one record completes on each return to FETCH or entry to HALT.
  initial begin
    bit   inflight = 0;
    int   m_off = 0, m_wen = 0, m_stat = 0, m_ramw = 0, m_ens = 0;
    int   m_a = -1, m_b = -1, m_c = -1, m_sa = 0;
    int   m_wsel = 0, m_rsel = 0, m_sav = 0;
    rec_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 0;
        sb.delete();
      end else begin
        if (w_en && ram_w_en) overlap++;
        if (inflight && (state_dbg == S_FETCH || state_dbg == S_HALT)) begin
          if (sb.size() == 0) begin
            chk($sformatf("i%0d_sb_underflow", idx), 0, 1);
          end else begin
            e = sb.pop_front();
            chk($sformatf("i%0d_cycles", idx), m_off, e.cyc);
            chk($sformatf("i%0d_w_en_cnt", idx), m_wen, e.wen);
            chk($sformatf("i%0d_status_cnt", idx), m_stat, e.stat);
            chk($sformatf("i%0d_ram_w_cnt", idx), m_ramw, e.ramw);
            chk($sformatf("i%0d_en_A_off", idx), m_a, e.a_off);
            chk($sformatf("i%0d_en_B_off", idx), m_b, e.b_off);
            chk($sformatf("i%0d_en_C_off", idx), m_c, e.c_off);
            chk($sformatf("i%0d_enable_cycles", idx), m_ens, e.ens);
            chk($sformatf("i%0d_sel_addr_cnt", idx), m_sa, e.sa_cnt);
            chk($sformatf("i%0d_halt", idx),
                int'(state_dbg == S_HALT), e.halt);
            if (e.wen > 0) begin
              chk($sformatf("i%0d_wb_sel", idx), m_wsel, e.wsel);
              chk($sformatf("i%0d_reg_sel", idx), m_rsel, e.rsel);
            end
            if (e.wen > 0 || e.ramw > 0)
              chk($sformatf("i%0d_wr_sel_addr", idx), m_sav, e.sa);
          end
          idx++;
          inflight = 0;
        end
        if (state_dbg == S_FETCH) begin
          inflight = 1;
          m_off = 0; m_wen = 0; m_stat = 0; m_ramw = 0; m_ens = 0;
          m_a = -1; m_b = -1; m_c = -1; m_sa = 0;
          m_wsel = 0; m_rsel = 0; m_sav = 0;
        end else if (inflight) begin
          m_off++;
          if (w_en) begin
            m_wen++;
            m_wsel = int'(wb_sel);
            m_rsel = int'(reg_sel);
            m_sav  = int'(sel_addr);
          end
          if (ram_w_en) begin
            m_ramw++;
            m_sav = int'(sel_addr);
          end
          if (en_status) m_stat++;
          if (en_A && m_a < 0) m_a = m_off;
          if (en_B && m_b < 0) m_b = m_off;
          if (en_C && m_c < 0) m_c = m_off;
          if (sel_addr) m_sa++;
          if (w_en || en_A || en_B || en_C || en_status ||
              load_addr || ram_w_en)
            m_ens++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    pi  = 0;
    rst = 1'b0;
  endtask

  task automatic wait_halt(string name, int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached_halt"}, int'(halted), 1);
    @(negedge clk);
    chk({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_state", int'(state_dbg), int'(S_RST));
    chk("rst_load_pc", int'(load_pc), 0);
    chk("rst_w_en", int'(w_en), 0);
    chk("rst_halted", int'(halted), 0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    chk("rst_illegal", int'(illegal), 0);
`endif

    prog = {MOVI, HLT};
    do_reset();
    wait_halt("p1", 200);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (halted && state_dbg == S_HALT) n++;
    end
    chk("p1_halt_hold", n, 25);

    prog = {MOVI, MOVI, ADD, CMP, MOVR, MVN, AND_, HLT};
    do_reset();
    wait_halt("p2", 400);

    prog = {LDR, STR, HLT};
    do_reset();
    wait_halt("p3", 200);

    prog = {ILL, HLT};
    do_reset();
    wait_halt("p4", 200);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    chk("p4_illegal_set", int'(illegal), 1);
`endif

    prog = {ADD, HLT};
    do_reset();
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    #1 chk("p5_illegal_cleared", int'(illegal), 0);
`endif
    n = 0;
    while (state_dbg != S_EXEC && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("p5_reached_exec", int'(state_dbg == S_EXEC), 1);
    #2 rst = 1'b1;
    #1;
    chk("p5_async_state", int'(state_dbg), int'(S_RST));
    chk("p5_async_en_C", int'(en_C), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("p5_hold_state", int'(state_dbg), int'(S_RST));
    chk("p5_hold_w_en", int'(w_en), 0);
    chk("p5_hold_load_pc", int'(load_pc), 0);
    prog = {HLT};
    pi = 0;
    #2 rst = 1'b0;
    #1;
    chk("p5_rel_load_pc", int'(load_pc && !pc_sel), 1);
    cnt = 1;
    repeat (10) begin
      @(negedge clk);
      if (load_pc && !pc_sel) cnt++;
    end
    chk("p5_start_pc_once", cnt, 1);
    wait_halt("p5", 100);

    chk("no_wen_ramw_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
